mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port of the shortest-path engine between NUM_CLIENTS requesters
//  (edge-cache fetch, prev/dist writeback, host loader). One transaction is in flight at a time.
//  Sits between the requesters and the top-level mem_* pins; no reordering, no buffering.
// PARAMETERS
//  NUM_CLIENTS   2                      requesters, 2..4; client index width CIW = $clog2(NUM_CLIENTS)
//  MADDR_WIDTH   `DEFAULT_MADDR_WIDTH   memory address width
//  MDATA_WIDTH   `DEFAULT_MDATA_WIDTH   memory data width
// PORTS
//  clock            in   1                 single clock, all logic on posedge
//  reset            in   1                 synchronous, active-high
//  cl_req           in   NUM_CLIENTS       level request, held until matching cl_done
//  cl_we            in   NUM_CLIENTS       1=write, 0=read; stable while cl_req high
//  cl_addr          in   NUM_CLIENTS*MADDR client i at [i*MADDR_WIDTH +: MADDR_WIDTH]
//  cl_wdata         in   NUM_CLIENTS*MDATA client i at [i*MDATA_WIDTH +: MDATA_WIDTH]
//  cl_done          out  NUM_CLIENTS       one-cycle pulse, transaction complete
//  cl_rdata         out  MDATA_WIDTH       read data, valid in cl_done cycle, held until next read
//  mem_read_enable  out  1                 registered
//  mem_write_enable out  1                 registered
//  mem_read_ready   in   1                 sampled only while mem_read_enable=1
//  mem_write_ready  in   1                 sampled only while mem_write_enable=1
//  mem_addr         out  MADDR_WIDTH       registered, granted client's address
//  mem_read_data    in   MDATA_WIDTH       captured when mem_read_ready sampled
//  mem_write_data   out  MDATA_WIDTH       registered, granted client's wdata
//  busy             out  1                 state != IDLE
//  grant_id         out  CIW               index of granted client, held while busy
// BEHAVIOUR
//  Reset: state=IDLE; all enables, cl_done, busy low; cl_rdata, mem_addr, mem_write_data, grant_id=0;
//   RR pointer=NUM_CLIENTS-1. Reset mid-transaction abandons it: no cl_done, enables low next cycle.
//  FSM IDLE -> BUSY -> RELEASE -> IDLE.
//   IDLE: any cl_req -> select winner, latch addr/wdata/we into mem_addr/mem_write_data, set
//     grant_id, raise read or write enable; -> BUSY (enable visible the cycle after req sampled).
//   BUSY: hold enable/addr/data; on sampled matching ready: capture mem_read_data (read),
//     drop enable, pulse cl_done[grant_id] next cycle; -> RELEASE. No timeout; waits indefinitely.
//   RELEASE: one-cycle turnaround (cl_done high this cycle); requests ignored; -> IDLE.
//  Latency: req at t, enable at t+1, ready at t+k (k>=1) -> cl_done at t+k+1; min 3-cycle period.
//  Ready of the non-active type, or ready while idle, is ignored.
//  Client dropping cl_req while granted: transaction still completes and cl_done still pulses.
//  Client keeping cl_req high after cl_done: treated as a new request in next IDLE.
//  Never both enables high; at most one cl_done bit high per cycle.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: winner = first requester after last granted index (wraps).
//   Pointer updates on each grant. No client waits more than NUM_CLIENTS-1 transactions.
//  Undefined: fixed priority, lowest index wins; client 0 may starve others (accepted).
// STRUCTURE
//  mem_arb_pkg: typedef enum {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_t; MAX_CLIENTS=4.
//  Sub-module mem_arb_picker: combinational winner select (req vector, last pointer ->
//   valid, index); the only place the round-robin macro is tested.
// TESTING
//  1 Client0 read 0x40, mem_read_ready 3 cycles after enable, data 0x1234 -> one cl_done[0],
//    cl_rdata=0x1234, mem_read_enable high exactly 3 cycles, mem_addr=0x40 throughout.
//  2 Client1 write 0x10/0xDEAD, mem_write_ready in first enable cycle -> cl_done[1] next cycle,
//    mem_write_data=0xDEAD while enabled, mem_read_enable never high.
//  3 Both clients req continuously, ready k=1: fixed -> grants 0,0,0...;
//    RR_EN -> grants 0,1,0,1 with a 3-cycle period.
//  4 Reset in 2nd BUSY cycle of a read -> enables low next cycle, no cl_done, busy=0;
//    a fresh client1 read then completes normally.
//  5 mem_read_ready/mem_write_ready pulsed while idle or during a write -> no cl_done,
//    no state change, cl_rdata unchanged.
//  6 Client0 drops cl_req in BUSY -> transaction still completes, cl_done[0] pulses once,
//    no re-grant of client0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory-port arbiter slice.
//   - arb_state_t : arbiter FSM state (IDLE -> BUSY -> RELEASE -> IDLE)
//   - MAX_CLIENTS : largest supported requester count
//   Also supplies fallback widths for the memory port when the build
//   does not define DEFAULT_MADDR_WIDTH / DEFAULT_MDATA_WIDTH.
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef DEFAULT_MDATA_WIDTH
`define DEFAULT_MDATA_WIDTH 16
`endif

package mem_arb_pkg;

  localparam int MAX_CLIENTS = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_picker.sv
// mem_arb_picker
//   Combinational winner select for the memory-port arbiter.
//   Ports:
//     req      in  NUM_CLIENTS  pending request vector
//     last_idx in  CIW          index granted most recently
//     valid    out 1            at least one request pending
//     idx      out CIW          winning client index (0 when !valid)
//   Build option MEM_ARB_ROUND_ROBIN_EN: defined -> round robin starting
//   just after last_idx; undefined -> fixed priority, lowest index wins.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2
) (
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [$clog2(NUM_CLIENTS)-1:0] last_idx,
  output logic                           valid,
  output logic [$clog2(NUM_CLIENTS)-1:0] idx
);

  localparam int CIW = $clog2(NUM_CLIENTS);

  assign valid = |req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Walk offsets from farthest to nearest so the requester closest after
  // last_idx is the final (winning) assignment.
  int cand;
  always_comb begin
    idx  = '0;
    cand = 0;
    for (int off = NUM_CLIENTS; off >= 1; off--) begin
      cand = (int'(last_idx) + off) % NUM_CLIENTS;
      if (req[cand]) idx = CIW'(cand);
    end
  end
`else
  // Pointer is irrelevant for fixed priority.
  logic unused_last;
  assign unused_last = ^last_idx;

  always_comb begin
    idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (req[i]) idx = CIW'(i);
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between NUM_CLIENTS requesters, one transaction
//   in flight, no buffering or reordering.
//   Ports:
//     clock, reset      single clock, synchronous active-high reset
//     cl_req/cl_we      per-client level request and direction (1=write)
//     cl_addr/cl_wdata  per-client address/write data, client i at slice i
//     cl_done           one-cycle completion pulse to the granted client
//     cl_rdata          last read data, held until the next read completes
//     mem_*             registered memory-side handshake and payload
//     busy              arbiter not idle
//     grant_id          granted client index, held while busy
//   Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration
//   (handled in mem_arb_picker); default is fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = `DEFAULT_MDATA_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CLIENTS-1:0]             cl_req,
  input  logic [NUM_CLIENTS-1:0]             cl_we,
  input  logic [NUM_CLIENTS*MADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*MDATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]             cl_done,
  output logic [MDATA_WIDTH-1:0]             cl_rdata,
  output logic                               mem_read_enable,
  output logic                               mem_write_enable,
  input  logic                               mem_read_ready,
  input  logic                               mem_write_ready,
  output logic [MADDR_WIDTH-1:0]             mem_addr,
  input  logic [MDATA_WIDTH-1:0]             mem_read_data,
  output logic [MDATA_WIDTH-1:0]             mem_write_data,
  output logic                               busy,
  output logic [$clog2(NUM_CLIENTS)-1:0]     grant_id
);

  localparam int CIW = $clog2(NUM_CLIENTS);

  // Flat client buses share the bit layout of these packed arrays.
  logic [NUM_CLIENTS-1:0][MADDR_WIDTH-1:0] addr_v;
  logic [NUM_CLIENTS-1:0][MDATA_WIDTH-1:0] wdata_v;
  assign addr_v  = cl_addr;
  assign wdata_v = cl_wdata;

  arb_state_t     state, state_d;
  logic [CIW-1:0] rr_ptr;
  logic           pick_valid;
  logic [CIW-1:0] pick_idx;
  logic           grant_fire;
  logic           xfer_done;

  mem_arb_picker #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_picker (
    .req      (cl_req),
    .last_idx (rr_ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Next state. Ready is only meaningful for the enable that is actually
  // up, so a wrong-type or idle-time ready never advances the FSM.
  always_comb begin
    state_d    = state;
    grant_fire = 1'b0;
    xfer_done  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d    = ARB_BUSY;
          grant_fire = 1'b1;
        end
      end
      ARB_BUSY: begin
        if ((mem_read_enable && mem_read_ready) ||
            (mem_write_enable && mem_write_ready)) begin
          state_d   = ARB_RELEASE;
          xfer_done = 1'b1;
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ARB_IDLE;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
      grant_id         <= '0;
      cl_done          <= '0;
      cl_rdata         <= '0;
      rr_ptr           <= CIW'(NUM_CLIENTS - 1);
    end else begin
      state   <= state_d;
      cl_done <= '0;
      if (grant_fire) begin
        mem_addr         <= addr_v[pick_idx];
        mem_write_data   <= wdata_v[pick_idx];
        mem_read_enable  <= ~cl_we[pick_idx];
        mem_write_enable <= cl_we[pick_idx];
        grant_id         <= pick_idx;
        rr_ptr           <= pick_idx;
      end
      if (xfer_done) begin
        mem_read_enable  <= 1'b0;
        mem_write_enable <= 1'b0;
        cl_done          <= NUM_CLIENTS'(1) << grant_id;
        if (mem_read_enable) cl_rdata <= mem_read_data;
      end
    end
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NC = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NC-1:0]     cl_req, cl_we, cl_done;
  logic [NC*AW-1:0]  cl_addr;
  logic [NC*DW-1:0]  cl_wdata;
  logic [DW-1:0]     cl_rdata, mem_read_data, mem_write_data;
  logic [AW-1:0]     mem_addr;
  logic              mem_read_enable, mem_write_enable;
  logic              mem_read_ready, mem_write_ready, busy;
  logic [0:0]        grant_id;

  logic [AW-1:0] ca [NC];
  logic [DW-1:0] cd [NC];

  always_comb begin
    cl_addr  = '0;
    cl_wdata = '0;
    for (int i = 0; i < NC; i++) begin
      cl_addr[i*AW +: AW]  = ca[i];
      cl_wdata[i*DW +: DW] = cd[i];
    end
  end

  mem_port_arbiter #(.NUM_CLIENTS(NC), .MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .cl_req(cl_req), .cl_we(cl_we),
    .cl_addr(cl_addr), .cl_wdata(cl_wdata), .cl_done(cl_done), .cl_rdata(cl_rdata),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .mem_write_data(mem_write_data),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cl_req = '0; cl_we = '0; mem_read_ready = 0; mem_write_ready = 0; mem_read_data = '0;
    for (int i = 0; i < NC; i++) begin ca[i] = '0; cd[i] = '0; end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  // Arbitration rule straight from the description: lowest index, or the
  // first requester after the last grant when round robin is built in.
  function automatic int pick(input logic [NC-1:0] r, input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int off = 1; off <= NC; off++) if (r[(last + off) % NC]) return (last + off) % NC;
`else
    for (int i = 0; i < NC; i++) if (r[i]) return i;
`endif
    return 0;
  endfunction

  function automatic int exp_rr_seq(input int k);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return k % NC;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    logic [1:0]  req, we;
    logic [15:0] addr, wd;
    logic        rrdy, wrdy;
    logic [15:0] rdin;
    logic [1:0]  e_done;
    logic        e_ren, e_wen, e_busy, e_gid;
    logic [15:0] e_addr, e_wd, e_rd;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] req, we, input logic [15:0] addr, wd,
                               input logic rrdy, wrdy, input logic [15:0] rdin,
                               input logic [1:0] e_done, input logic e_ren, e_wen, e_busy, e_gid,
                               input logic [15:0] e_addr, e_wd, e_rd);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wd = wd; v.rrdy = rrdy; v.wrdy = wrdy; v.rdin = rdin;
    v.e_done = e_done; v.e_ren = e_ren; v.e_wen = e_wen; v.e_busy = e_busy; v.e_gid = e_gid;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_rd = e_rd;
    return v;
  endfunction

  vec_t tbl [9];

  // Reference model state (transaction level)
  bit          m_act, m_we;
  int          m_cli, m_last, m_gcyc, m_dcyc, m_free;
  logic [15:0] m_addr, m_wd, m_rd;

  initial begin
    int ren_cnt, k, w;
    logic [NC-1:0] exp_done;

    // client1 write with immediate ready, then stray readies while idle
    // and during a client0 write
    tbl[0] = mkv(2'b10, 2'b10, 16'h0010, 16'hDEAD, 0, 0, 16'h0000, 2'b00, 0, 1, 1, 1, 16'h0010, 16'hDEAD, 16'h0);
    tbl[1] = mkv(2'b10, 2'b10, 16'h0010, 16'hDEAD, 0, 1, 16'h0000, 2'b10, 0, 0, 1, 1, 16'h0010, 16'hDEAD, 16'h0);
    tbl[2] = mkv(2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 1, 16'h0010, 16'hDEAD, 16'h0);
    tbl[3] = mkv(2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 16'h5555, 2'b00, 0, 0, 0, 1, 16'h0010, 16'hDEAD, 16'h0);
    tbl[4] = mkv(2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 16'h6666, 2'b00, 0, 0, 0, 1, 16'h0010, 16'hDEAD, 16'h0);
    tbl[5] = mkv(2'b01, 2'b01, 16'h0022, 16'hBEEF, 1, 0, 16'h7777, 2'b00, 0, 1, 1, 0, 16'h0022, 16'hBEEF, 16'h0);
    tbl[6] = mkv(2'b01, 2'b01, 16'h0022, 16'hBEEF, 1, 0, 16'h7777, 2'b00, 0, 1, 1, 0, 16'h0022, 16'hBEEF, 16'h0);
    tbl[7] = mkv(2'b01, 2'b01, 16'h0022, 16'hBEEF, 1, 1, 16'h7777, 2'b01, 0, 0, 1, 0, 16'h0022, 16'hBEEF, 16'h0);
    tbl[8] = mkv(2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 0, 16'h0022, 16'hBEEF, 16'h0);

    // reset state
    idle_inputs();
    reset = 1;
    step();
    step();
    chk("rst_ren", mem_read_enable, 0);
    chk("rst_wen", mem_write_enable, 0);
    chk("rst_done", cl_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wd", mem_write_data, 0);
    chk("rst_rd", cl_rdata, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      cl_req = tbl[i].req; cl_we = tbl[i].we;
      for (int c = 0; c < NC; c++) begin ca[c] = tbl[i].addr; cd[c] = tbl[i].wd; end
      mem_read_ready = tbl[i].rrdy; mem_write_ready = tbl[i].wrdy; mem_read_data = tbl[i].rdin;
      step();
      chk($sformatf("tbl%0d_done", i), cl_done, tbl[i].e_done);
      chk($sformatf("tbl%0d_ren", i), mem_read_enable, tbl[i].e_ren);
      chk($sformatf("tbl%0d_wen", i), mem_write_enable, tbl[i].e_wen);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].e_gid);
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_wd", i), mem_write_data, tbl[i].e_wd);
      chk($sformatf("tbl%0d_rd", i), cl_rdata, tbl[i].e_rd);
    end
    idle_inputs();

    // client0 read, ready in the third enable cycle
    ca[0] = 16'h0040; cl_we = 2'b00; cl_req = 2'b01;
    step();
    ren_cnt = 0;
    for (int j = 1; j <= 3; j++) begin
      chk("rd_ren", mem_read_enable, 1);
      chk("rd_addr", mem_addr, 16'h0040);
      chk("rd_nodone", cl_done, 0);
      ren_cnt += int'(mem_read_enable);
      if (j == 3) begin mem_read_ready = 1; mem_read_data = 16'h1234; end
      step();
    end
    chk("rd_done", cl_done, 2'b01);
    chk("rd_ren_off", mem_read_enable, 0);
    chk("rd_data", cl_rdata, 16'h1234);
    chk("rd_ren_cycles", ren_cnt, 3);
    idle_inputs();
    step();
    chk("rd_done_once", cl_done, 0);
    chk("rd_idle", busy, 0);

    // reset in the second busy cycle of a read, then a fresh client1 read
    ca[0] = 16'h0050; cl_we = 2'b00; cl_req = 2'b01;
    step();
    step();
    reset = 1;
    step();
    reset = 0; cl_req = 2'b00;
    chk("rs_ren", mem_read_enable, 0);
    chk("rs_done", cl_done, 0);
    chk("rs_busy", busy, 0);
    step();
    chk("rs_done2", cl_done, 0);
    chk("rs_busy2", busy, 0);
    ca[1] = 16'h0030; cl_req = 2'b10;
    step();
    chk("rs_ren1", mem_read_enable, 1);
    chk("rs_gid1", grant_id, 1);
    chk("rs_addr1", mem_addr, 16'h0030);
    mem_read_ready = 1; mem_read_data = 16'hABCD;
    step();
    chk("rs_done1", cl_done, 2'b10);
    chk("rs_data1", cl_rdata, 16'hABCD);
    idle_inputs();
    step();

    // both clients requesting continuously, ready as soon as enabled
    do_reset();
    cl_req = 2'b11; cl_we = 2'b00; mem_read_ready = 1; mem_read_data = 16'h0101;
    k = 0;
    for (int t = 1; t <= 9; t++) begin
      step();
      if (t % 3 == 1) begin
        chk("both_ren", mem_read_enable, 1);
        chk("both_gid", grant_id, exp_rr_seq(k));
      end else if (t % 3 == 2) begin
        exp_done = NC'(1) << exp_rr_seq(k);
        chk("both_done", cl_done, exp_done);
        k++;
      end else begin
        chk("both_idle", busy, 0);
      end
    end
    idle_inputs();
    step();

    // client0 drops its request mid-read
    ca[0] = 16'h0060; cl_we = 2'b00; cl_req = 2'b01;
    step();
    chk("drop_ren", mem_read_enable, 1);
    cl_req = 2'b00;
    step();
    step();
    chk("drop_hold", mem_read_enable, 1);
    chk("drop_busy", busy, 1);
    mem_read_ready = 1; mem_read_data = 16'h4242;
    step();
    chk("drop_done", cl_done, 2'b01);
    chk("drop_data", cl_rdata, 16'h4242);
    mem_read_ready = 0;
    step();
    chk("drop_done_once", cl_done, 0);
    step();
    chk("drop_noregrant", mem_read_enable, 0);
    chk("drop_idle", busy, 0);

    // randomized traffic against the transaction model
    do_reset();
    m_act = 0; m_we = 0; m_cli = 0; m_last = NC - 1; m_gcyc = 0; m_dcyc = -10; m_free = 0;
    m_addr = '0; m_wd = '0; m_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NC; i++) begin
        if (cl_req[i]) begin
          if (cl_done[i] && $urandom_range(3) != 0) cl_req[i] = 0;
        end else if ($urandom_range(2) == 0) begin
          cl_req[i] = 1; cl_we[i] = 1'($urandom); ca[i] = 16'($urandom); cd[i] = 16'($urandom);
        end
      end
      mem_read_ready  = ($urandom_range(2) == 0);
      mem_write_ready = ($urandom_range(2) == 0);
      mem_read_data   = 16'($urandom);

      if (!m_act && c >= m_free && |cl_req) begin
        w = pick(cl_req, m_last);
        m_act = 1; m_cli = w; m_last = w; m_gcyc = c;
        m_we = cl_we[w]; m_addr = ca[w]; m_wd = cd[w];
      end else if (m_act && c > m_gcyc && (m_we ? mem_write_ready : mem_read_ready)) begin
        m_act = 0; m_dcyc = c + 1; m_free = c + 2;
        if (!m_we) m_rd = mem_read_data;
      end

      step();
      exp_done = (m_dcyc == c + 1) ? (NC'(1) << m_cli) : '0;
      chk("rnd_done", cl_done, exp_done);
      chk("rnd_ren", mem_read_enable, m_act && !m_we);
      chk("rnd_wen", mem_write_enable, m_act && m_we);
      chk("rnd_busy", busy, m_act || (m_dcyc == c + 1));
      chk("rnd_gid", grant_id, m_cli);
      chk("rnd_addr", mem_addr, m_addr);
      chk("rnd_wd", mem_write_data, m_wd);
      chk("rnd_rd", cl_rdata, m_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
